// File: rtl/dmem_ctrl.sv
// dmem_ctrl -- data-memory access controller for the MEM stage.
//
// Accepts one load/store from the MEM stage, issues a single-outstanding
// wait-stated bus cycle, steers store data onto byte lanes and extends load
// data. stallreq_o holds the pipeline until the access completes.
// Misaligned requests complete in one cycle with misalign_o set and no bus
// cycle.
//
// Optional build macro: DMEM_TIMEOUT_EN
//   When defined, a BUS-state wait counter ends an unacknowledged access after
//   TIMEOUT_CYCLES wait cycles and reports it on bus_err_o. An ack that arrives
//   on the timeout edge takes priority over the timeout. When undefined, the
//   controller waits indefinitely and bus_err_o is tied low.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_i           load/store request, held until done_o
//   we_i            1 = store, 0 = load
//   size_i          00 byte, 01 half, 10/11 word
//   sign_ext_i      sign-extend (LB/LH) vs zero-extend (LBU/LHU)
//   addr_i          byte address
//   wdata_i         right-aligned store data
//   rdata_o         extended load result (valid with done_o, held after)
//   done_o          one-cycle completion pulse
//   stallreq_o      stall request toward stall_control
//   misalign_o      misaligned-access flag (valid with done_o, held after)
//   bus_req_o       bus request
//   bus_we_o        bus write enable
//   bus_addr_o      word-aligned bus address
//   bus_be_o        byte enables
//   bus_wdata_o     lane-replicated store data
//   bus_ack_i       bus completion, honoured only while bus_req_o=1
//   bus_rdata_i     bus read data, valid with bus_ack_i
//   bus_err_o       timeout flag (DMEM_TIMEOUT_EN only)

module dmem_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              sign_ext_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              done_o,
  output logic              stallreq_o,
  output logic              misalign_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              bus_err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                bus_req_q, bus_req_d;
  logic                done_q, done_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [3:0]          bus_be_q, bus_be_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [1:0]          size_q, size_d;
  logic                sign_q, sign_d;
  logic [1:0]          lane_q, lane_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                misalign_q, misalign_d;
  logic                err_q, err_d;

  // Request decode for the incoming access
  logic                req_misaligned;
  logic [3:0]          req_be;
  logic [DATA_W-1:0]   req_wdata;

  // Pick the addressed byte/half out of the bus word and extend it.
  function automatic logic [DATA_W-1:0] load_ext(
    input logic [1:0]        size,
    input logic              sx,
    input logic [1:0]        lane,
    input logic [DATA_W-1:0] d
  );
    logic [DATA_W-1:0] sh;
    logic [15:0]       hw;
    sh = d >> {lane, 3'b000};
    hw = lane[1] ? d[31:16] : d[15:0];
    case (size)
      2'b00:   load_ext = {{24{sx & sh[7]}}, sh[7:0]};
      2'b01:   load_ext = {{16{sx & hw[15]}}, hw};
      default: load_ext = d;
    endcase
  endfunction

  // size 11 is a word, so size_i[1] alone selects word alignment rules.
  assign req_misaligned = ((size_i == 2'b01) && addr_i[0]) ||
                          (size_i[1] && (addr_i[1:0] != 2'b00));

  always_comb begin
    req_be    = 4'b1111;
    req_wdata = wdata_i;
    case (size_i)
      2'b00: begin
        req_be    = 4'b0001 << addr_i[1:0];
        req_wdata = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        req_be    = addr_i[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{wdata_i[15:0]}};
      end
      default: begin
        req_be    = 4'b1111;
        req_wdata = wdata_i;
      end
    endcase
  end

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  localparam int timeout_cycles_unused = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    done_d      = 1'b0;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    size_d      = size_q;
    sign_d      = sign_q;
    lane_d      = lane_q;
    rdata_d     = rdata_q;
    misalign_d  = misalign_q;
    err_d       = err_q;
`ifdef DMEM_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          if (req_misaligned) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            rdata_d    = '0;
            misalign_d = 1'b1;
            err_d      = 1'b0;
          end else begin
            state_d     = S_BUS;
            bus_req_d   = 1'b1;
            bus_we_d    = we_i;
            bus_addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
            bus_be_d    = req_be;
            bus_wdata_d = req_wdata;
            size_d      = size_i;
            sign_d      = sign_ext_i;
            lane_d      = addr_i[1:0];
`ifdef DMEM_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end
        end
      end
      S_BUS: begin
        if (bus_ack_i) begin
          state_d    = S_DONE;
          bus_req_d  = 1'b0;
          done_d     = 1'b1;
          rdata_d    = bus_we_q ? '0 : load_ext(size_q, sign_q, lane_q, bus_rdata_i);
          misalign_d = 1'b0;
          err_d      = 1'b0;
        end
`ifdef DMEM_TIMEOUT_EN
        // The edge on which the counter would reach the limit ends the access.
        else if (cnt_q == CNT_LAST) begin
          state_d    = S_DONE;
          bus_req_d  = 1'b0;
          done_d     = 1'b1;
          rdata_d    = '0;
          misalign_d = 1'b0;
          err_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bus_req_q   <= 1'b0;
      done_q      <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      size_q      <= '0;
      sign_q      <= 1'b0;
      lane_q      <= '0;
      rdata_q     <= '0;
      misalign_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      done_q      <= done_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
      lane_q      <= lane_d;
      rdata_q     <= rdata_d;
      misalign_q  <= misalign_d;
      err_q       <= err_d;
    end
  end

  assign rdata_o     = rdata_q;
  assign done_o      = done_q;
  assign misalign_o  = misalign_q;
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_be_o    = bus_be_q;
  assign bus_wdata_o = bus_wdata_q;
  // Dropping the stall in DONE lets the pipeline advance on the DONE edge.
  assign stallreq_o  = req_i & (state_q != S_DONE);

`ifdef DMEM_TIMEOUT_EN
  assign bus_err_o = err_q;
`else
  assign bus_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i, we_i, sign_ext_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, wdata_i;
  logic [31:0] rdata_o;
  logic        done_o, stallreq_o, misalign_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic        bus_err_o;

  int n_vec = 0;
  int n_err = 0;

  dmem_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .sign_ext_i(sign_ext_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .done_o(done_o), .stallreq_o(stallreq_o),
    .misalign_o(misalign_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
  endfunction

  function automatic logic m_mis(input logic [1:0] s, input logic [31:0] a);
    return (a % nbytes(s)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] s, input logic [31:0] a);
    int nb;
    int off;
    nb  = nbytes(s);
    off = int'(a % 4);
    return 4'(((1 << nb) - 1) << off);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] s, input logic [31:0] w);
    int nb;
    nb = nbytes(s);
    if (nb == 1) return (w & 32'hFF) * 32'h0101_0101;
    if (nb == 2) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] s, input logic sx,
                                         input logic [31:0] a, input logic [31:0] d);
    int nb;
    logic [31:0] v, mask;
    nb = nbytes(s);
    if (nb == 4) return d;
    mask = (32'd1 << (8 * nb)) - 32'd1;
    v = (d >> (8 * (a % 4))) & mask;
    if (sx && v[8 * nb - 1]) v = v | ~mask;
    return v;
  endfunction

  // One access. Called just after a rising edge; that cycle is cycle 0.
  // waits < 0 means the bus never acknowledges (timeout build only).
  task automatic run_xact(input string nm, input logic we, input logic [1:0] sz,
                          input logic sx, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int waits);
    logic        mis;
    logic        exp_err;
    int          d_cyc;
    int          ack_cyc;
    logic [31:0] exp_r;
    mis     = m_mis(sz, a);
    exp_err = 1'b0;
    if (mis) begin
      d_cyc   = 1;
      ack_cyc = -1;
      exp_r   = 32'h0;
    end else if (waits < 0) begin
      d_cyc   = TO + 1;
      ack_cyc = -1;
      exp_r   = 32'h0;
      exp_err = 1'b1;
    end else begin
      d_cyc   = waits + 2;
      ack_cyc = waits + 1;
      exp_r   = we ? 32'h0 : m_load(sz, sx, a, rd);
    end

    req_i = 1'b1; we_i = we; size_i = sz; sign_ext_i = sx; addr_i = a; wdata_i = wd;
    bus_ack_i   = 1'($urandom_range(0, 1));   // ack while idle must be ignored
    bus_rdata_i = $urandom;
    @(negedge clk);
    chk("stall_c0", stallreq_o, 1);
    chk("busreq_c0", bus_req_o, 0);
    chk("done_c0", done_o, 0);

    for (int c = 1; c <= d_cyc; c++) begin
      @(posedge clk); #1;
      if (c == ack_cyc) begin
        bus_ack_i = 1'b1; bus_rdata_i = rd;
      end else begin
        bus_ack_i = (c == d_cyc) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus_rdata_i = $urandom;
      end
      @(negedge clk);
      chk("done", done_o, (c == d_cyc));
      chk("bus_req", bus_req_o, (!mis && c < d_cyc));
      chk("stall", stallreq_o, (c != d_cyc));
      if (!mis && c < d_cyc) begin
        chk("bus_addr", bus_addr_o, a & 32'hFFFF_FFFC);
        chk("bus_be", bus_be_o, m_be(sz, a));
        chk("bus_we", bus_we_o, we);
        if (we) chk("bus_wdata", bus_wdata_o, m_wdata(sz, wd));
      end
      if (c == d_cyc) begin
        chk("rdata", rdata_o, exp_r);
        chk("misalign", misalign_o, mis);
        chk("bus_err", bus_err_o, exp_err);
      end
    end

    @(posedge clk); #1;
    req_i = 1'b0; bus_ack_i = 1'b0;
    @(negedge clk);
    chk("done_pulse_len", done_o, 0);
    chk("rdata_hold", rdata_o, exp_r);
    chk("misalign_hold", misalign_o, mis);
    $display("xact %-10s we=%0d size=%0d sx=%0d addr=%h wdata=%h waits=%0d -> rdata=%h mis=%0d err=%0d",
             nm, we, sz, sx, a, wd, waits, rdata_o, misalign_o, bus_err_o);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; req_i = 1'b0; we_i = 1'b0; size_i = 2'd0; sign_ext_i = 1'b0;
    addr_i = 32'h0; wdata_i = 32'h0; bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_mis", misalign_o, 0);
    chk("rst_busreq", bus_req_o, 0);
    chk("rst_buswe", bus_we_o, 0);
    chk("rst_busaddr", bus_addr_o, 0);
    chk("rst_busbe", bus_be_o, 0);
    chk("rst_buswdata", bus_wdata_o, 0);
    chk("rst_buserr", bus_err_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // directed cases
    run_xact("LW",  1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0);
    run_xact("LB",  1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0,         32'h8011_2233, 0);
    run_xact("LBU", 1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0,         32'h8011_2233, 0);
    run_xact("SH",  1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 32'h0,         3);
    run_xact("SWmis", 1'b1, 2'd2, 1'b0, 32'h0000_0101, 32'h1234_5678, 32'h0,       0);
    run_xact("LHmis", 1'b0, 2'd1, 1'b1, 32'h0000_0105, 32'h0,       32'hFFFF_FFFF, 0);
    run_xact("LH",  1'b0, 2'd1, 1'b1, 32'h0000_0402, 32'h0,         32'h8001_7FFF, 1);
    run_xact("LW11", 1'b0, 2'd3, 1'b1, 32'h0000_0408, 32'h0,        32'h8765_4321, 2);

    // randomized accesses
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & ~32'h3 | (32'($urandom_range(0, 1)) << 1) & 32'h2;
      run_xact("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), a, $urandom, $urandom, $urandom_range(0, 4));
    end

    // reset during a BUS wait, followed by a late ack
    req_i = 1'b1; we_i = 1'b0; size_i = 2'd2; sign_ext_i = 1'b0; addr_i = 32'h300;
    bus_ack_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid_busreq_pre", bus_req_o, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; req_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFE_F00D;
    @(negedge clk);
    chk("rstmid_busreq", bus_req_o, 0);
    chk("rstmid_done", done_o, 0);
    chk("rstmid_addr", bus_addr_o, 0);
    @(posedge clk); #1;
    bus_ack_i = 1'b0;
    @(negedge clk);
    chk("rstmid_done2", done_o, 0);
    chk("rstmid_rdata", rdata_o, 0);
    chk("rstmid_busreq2", bus_req_o, 0);
    $display("xact rst-mid   reset during bus wait, late ack ignored");
    @(posedge clk); #1;
    // controller must be idle: a misaligned request completes in one cycle
    run_xact("postrst", 1'b0, 2'd1, 1'b0, 32'h0000_0011, 32'h0, 32'h0, 0);

`ifdef DMEM_TIMEOUT_EN
    run_xact("timeout", 1'b0, 2'd2, 1'b0, 32'h0000_0500, 32'h0, 32'h0, -1);
    run_xact("ack@to",  1'b0, 2'd2, 1'b0, 32'h0000_0500, 32'h0, 32'h1357_9BDF, TO - 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Data-memory access controller for the MEM stage of the 5-stage MIPS pipeline. It takes one load/store request from the MEM stage and drives a single-outstanding, wait-stated data bus. It performs byte-lane steering and load extension, and holds stallreq_o high toward stall_control until the access completes. It flags misaligned accesses without issuing any bus cycle.

Parameters:
ADDR_W, 32, address width (byte address)
DATA_W, 32, data width; fixed at 32, and other values are unsupported
TIMEOUT_CYCLES, 255, wait-cycle limit; used only with DMEM_TIMEOUT_EN

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_i  in  1  MEM stage has a load/store; held until done_o
we_i  in  1  1 = store, 0 = load
size_i  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word
sign_ext_i  in  1  load sign-extend (LB/LH) vs zero-extend (LBU/LHU)
addr_i  in  32  byte address
wdata_i  in  32  store data, right-aligned
rdata_o  out  32  extended load result; valid when done_o=1
done_o  out  1  one-cycle completion pulse
stallreq_o  out  1  stall request to stall_control
misalign_o  out  1  misaligned-access flag, coincident with done_o
bus_req_o  out  1  bus request
bus_we_o  out  1  bus write enable
bus_addr_o  out  32  word-aligned address (addr_i[31:2], 2'b00)
bus_be_o  out  4  byte enables
bus_wdata_o  out  32  lane-replicated store data
bus_ack_i  in  1  bus completion, sampled on clk while bus_req_o=1
bus_rdata_i  in  32  read data, valid with bus_ack_i
bus_err_o  out  1  timeout flag; only with DMEM_TIMEOUT_EN, otherwise tied 0

Behaviour:
- Reset (synchronous): state = IDLE. All outputs 0: rdata_o, done_o, misalign_o, bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, bus_err_o.
- Reset mid-access: the in-flight access is abandoned. bus_req_o is 0 in the cycle after the reset edge, and a late bus_ack_i is ignored.
- Little-endian lane mapping:
  - byte: be = 1 << addr[1:0]; wdata = {4{wdata_i[7:0]}}.
  - half: be = addr[1] ? 1100 : 0011; wdata = {2{wdata_i[15:0]}}.
  - word: be = 1111; wdata = wdata_i.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=00.
- Load extraction: select the byte or half selected by addr from bus_rdata_i, then sign- or zero-extend per sign_ext_i. Word loads pass through unchanged.
- IDLE:
  - If req_i is aligned: latch addr, we, be, wdata, size, sign_ext, addr[1:0]; go to BUS.
  - If req_i is misaligned: go to DONE with misalign_o=1 and rdata_o=0; no bus cycle is issued.
- BUS:
  - bus_req_o=1. Bus address, we, be and wdata are registered and stable for the whole cycle.
  - When bus_ack_i=1 at an edge: capture the extended read data (loads; stores give rdata_o=0), drop bus_req_o, go to DONE.
  - A zero-wait ack in the first BUS cycle is legal.
- DONE: done_o=1 for exactly one cycle, then IDLE. rdata_o and misalign_o hold their values until the next DONE.
- stallreq_o (combinational) = req_i & (state != DONE). The stall therefore drops in the DONE cycle so the pipeline advances on that edge.
- Latency, aligned request first seen in cycle 0 with ack in the first BUS cycle:
  - cycle 1: bus_req_o=1
  - cycle 2: done_o=1
  - With N wait cycles, done_o arrives in cycle 2+N.
- Misaligned latency: done_o in cycle 1.
- req_i falling while in BUS (pipeline flush): the bus cycle still completes, because the bus is non-abortable. DONE is still entered, and done_o is ignored by MEM.
- bus_ack_i outside BUS is ignored.

Optional Feature:
DMEM_TIMEOUT_EN
- Defined:
  - A wait counter clears on BUS entry and increments each BUS cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES with no ack: drop bus_req_o and go to DONE with rdata_o=0 and bus_err_o=1.
  - bus_err_o holds until the next DONE.
  - If ack and timeout occur on the same edge, ack wins.
- Undefined: no counter; BUS waits indefinitely; bus_err_o is tied 0.

Test Plan:
- Word load, addr=0x100, ack on first BUS cycle, bus_rdata_i=0xDEADBEEF -> bus_be_o=1111, bus_addr_o=0x100; done_o in cycle 2; rdata_o=0xDEADBEEF; stallreq_o high in cycles 0-1 and low in cycle 2.
- LB at addr=0x103 with bus_rdata_i=0x80112233 -> bus_be_o=1000, rdata_o=0xFFFFFF80. LBU with the same data -> rdata_o=0x00000080.
- SH at addr=0x202, wdata_i=0x0000ABCD, ack after 3 wait cycles -> bus_we_o=1, bus_be_o=1100, bus_wdata_o=0xABCDABCD; done_o in cycle 5.
- Word store at addr=0x101 -> no bus_req_o; done_o and misalign_o in cycle 1; stallreq_o high only in cycle 0.
- rst asserted during BUS wait, then bus_ack_i=1 in the following cycle -> bus_req_o=0 after the reset edge, no done_o, state IDLE.
- DMEM_TIMEOUT_EN with TIMEOUT_CYCLES=4 and ack never asserted -> done_o with bus_err_o=1 and rdata_o=0 after 4 wait cycles. A repeat run with ack on the timeout edge -> bus_err_o=0 and the data is returned.
